// File: rtl/math_pipelined_sequencer.sv
// math_pipelined_sequencer: valid/ready front-end that holds ALU operands for SETTLE_CYCLES clocks, then captures all results.
// Define MATH_SEQ_SKID_EN to add a one-entry operand skid buffer for back-to-back operation.
module math_pipelined_sequencer #(
   parameter int WIDTH         = 4,
   parameter int LATENCY       = 4,
   parameter int SETTLE_CYCLES = LATENCY + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_I1,
   input  logic [WIDTH-1:0] s_I2,
   input  logic [WIDTH-1:0] s_I3,
   output logic [WIDTH-1:0] op_I1,
   output logic [WIDTH-1:0] op_I2,
   output logic [WIDTH-1:0] op_I3,
   input  logic [WIDTH-1:0] alu_sum,
   input  logic [WIDTH-1:0] alu_sub,
   input  logic [4:0]       alu_flags,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_sum,
   output logic [WIDTH-1:0] m_sub,
   output logic [4:0]       m_flags,
   output logic             busy
);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          acc;
   logic          hs;

   assign acc  = s_valid & s_ready;
   assign hs   = m_valid & m_ready;
   assign busy = state != IDLE;

`ifdef MATH_SEQ_SKID_EN
   logic             sk_full;
   logic [WIDTH-1:0] sk_i1, sk_i2, sk_i3;
   assign s_ready = !sk_full;
`else
   assign s_ready = state == IDLE;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         op_I1   <= '0;
         op_I2   <= '0;
         op_I3   <= '0;
         m_valid <= 1'b0;
         m_sum   <= '0;
         m_sub   <= '0;
         m_flags <= '0;
`ifdef MATH_SEQ_SKID_EN
         sk_full <= 1'b0;
         sk_i1   <= '0;
         sk_i2   <= '0;
         sk_i3   <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (acc) begin
               op_I1 <= s_I1;
               op_I2 <= s_I2;
               op_I3 <= s_I3;
               cnt   <= CNT_LOAD;
               state <= HOLD;
            end
            HOLD: if (cnt == '0) begin
               m_sum   <= alu_sum;
               m_sub   <= alu_sub;
               m_flags <= alu_flags;
               m_valid <= 1'b1;
               state   <= DONE;
            end else cnt <= cnt - 1'b1;
            DONE: if (hs) begin
               m_valid <= 1'b0;
               state   <= IDLE;
`ifdef MATH_SEQ_SKID_EN
               // A queued operand, or one arriving right now, restarts HOLD without visiting IDLE
               if (sk_full) begin
                  op_I1 <= sk_i1;
                  op_I2 <= sk_i2;
                  op_I3 <= sk_i3;
                  cnt   <= CNT_LOAD;
                  state <= HOLD;
               end else if (acc) begin
                  op_I1 <= s_I1;
                  op_I2 <= s_I2;
                  op_I3 <= s_I3;
                  cnt   <= CNT_LOAD;
                  state <= HOLD;
               end
`endif
            end
            default: state <= IDLE;
         endcase
`ifdef MATH_SEQ_SKID_EN
         if (state == DONE && hs) sk_full <= 1'b0;
         else if (acc && state != IDLE) begin
            sk_full <= 1'b1;
            sk_i1   <= s_I1;
            sk_i2   <= s_I2;
            sk_i3   <= s_I3;
         end
`endif
      end
endmodule

// File: tb/tb_math_pipelined_sequencer.sv
// tb_math_pipelined_sequencer: scoreboard bench for the sequencer with a behavioural stand-in for the pipelined ALU.
// Builds with or without MATH_SEQ_SKID_EN; skid-dependent expectations follow the macro.
module tb_math_pipelined_sequencer;
   localparam int W      = 8;
   localparam int LAT    = 4;
   localparam int SETTLE = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [W-1:0] s_I1 = '0, s_I2 = '0, s_I3 = '0;
   logic [W-1:0] op_I1, op_I2, op_I3;
   logic [W-1:0] alu_sum, alu_sub;
   logic [4:0]   alu_flags;
   logic         m_valid;
   logic         m_ready = 1'b0;
   logic [W-1:0] m_sum, m_sub;
   logic [4:0]   m_flags;
   logic         busy;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   bit prev_mv = 1'b0;
   bit last_acc = 1'b0;
   logic [20:0] exp_q[$];
   int          acc_q[$];

   math_pipelined_sequencer #(.WIDTH(W), .LATENCY(LAT), .SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_I1(s_I1), .s_I2(s_I2), .s_I3(s_I3),
      .op_I1(op_I1), .op_I2(op_I2), .op_I3(op_I3),
      .alu_sum(alu_sum), .alu_sub(alu_sub), .alu_flags(alu_flags),
      .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_sub(m_sub),
      .m_flags(m_flags), .busy(busy)
   );

   always #5 clk = ~clk;

   // {sum, sub, neq, eq, xor, or, and}; gates are reduced so that every result bit is exercised
   function automatic logic [20:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      return {a + b, a - b, a != c, a == c, &(a ^ b), |(a | b), &(a & b)};
   endfunction

   // ALU stand-in with LAT register stages, so an early capture sees stale results
   logic [20:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= model(op_I1, op_I2, op_I3);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign {alu_sum, alu_sub, alu_flags} = pipe[LAT-1];

   // One clock: scoreboard push/pop at the negedge, then return just after the next rising edge
   task automatic step();
      logic [20:0] e, got;
      int a;
      @(negedge clk);
      last_acc = rst_n && s_valid && s_ready;
      if (last_acc) begin
         exp_q.push_back(model(s_I1, s_I2, s_I3));
         acc_q.push_back(cyc + 1);
      end
      if (rst_n && m_valid && !prev_mv) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: result %h with no accepted operand", {m_sum, m_sub, m_flags});
         end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            got = {m_sum, m_sub, m_flags};
            if (got !== e) begin
               errors++;
               $display("FAIL sb_data: got %h expected %h", got, e);
            end
            vectors++;
            if (cyc - a !== SETTLE) begin
               errors++;
               $display("FAIL sb_latency: got %0d edges expected %0d", cyc - a, SETTLE);
            end
         end
      end
      prev_mv = rst_n && m_valid;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      int n = 0;
      s_valid = 1'b1;
      s_I1 = a;
      s_I2 = b;
      s_I3 = c;
      do begin
         step();
         n++;
      end while (!last_acc && n < 100);
      s_valid = 1'b0;
      vectors++;
      if (!last_acc) begin
         errors++;
         $display("FAIL send_timeout: accepted %0d expected 1", last_acc);
      end
   endtask

   task automatic wait_mv();
      int n = 0;
      while (!m_valid && n < 100) begin
         step();
         n++;
      end
      vectors++;
      if (!m_valid) begin
         errors++;
         $display("FAIL mv_timeout: m_valid %b expected 1", m_valid);
      end
   endtask

   task automatic drain();
      m_ready = 1'b1;
      s_valid = 1'b0;
      for (int i = 0; i < 2 * SETTLE + 4; i++) step();
   endtask

   task automatic test_reset();
      step();
      step();
      vectors++;
      if ({s_ready, m_valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL reset_ctrl: {s_ready,m_valid,busy}=%b expected 100", {s_ready, m_valid, busy});
      end
      vectors++;
      if ({op_I1, op_I2, op_I3} !== 24'h0) begin
         errors++;
         $display("FAIL reset_op: got %h expected 0", {op_I1, op_I2, op_I3});
      end
      vectors++;
      if ({m_sum, m_sub, m_flags} !== 21'h0) begin
         errors++;
         $display("FAIL reset_m: got %h expected 0", {m_sum, m_sub, m_flags});
      end
      rst_n = 1'b1;
      step();
      vectors++;
      if ({s_ready, busy} !== 2'b10) begin
         errors++;
         $display("FAIL idle_ready: {s_ready,busy}=%b expected 10", {s_ready, busy});
      end
   endtask

   task automatic test_basic();
      m_ready = 1'b1;
      send(8'hFF, 8'h01, 8'hFF);
      vectors++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_hold: got %b expected 1", busy);
      end
      wait_mv();
      vectors++;
      if ({m_sum, m_sub, m_flags} !== {8'h00, 8'hFE, 5'b01010}) begin
         errors++;
         $display("FAIL basic_result: got %h expected %h", {m_sum, m_sub, m_flags}, {8'h00, 8'hFE, 5'b01010});
      end
      drain();
   endtask

   task automatic test_hold_result();
      bit exp_sr;
`ifdef MATH_SEQ_SKID_EN
      exp_sr = 1'b1;
`else
      exp_sr = 1'b0;
`endif
      m_ready = 1'b0;
      send(8'h3C, 8'h3C, 8'h00);
      wait_mv();
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if ({m_valid, m_sum, m_sub, m_flags, s_ready} !== {1'b1, 8'h78, 8'h00, 5'b10010, exp_sr}) begin
            errors++;
            $display("FAIL hold_result: got %h expected %h", {m_valid, m_sum, m_sub, m_flags, s_ready},
                     {1'b1, 8'h78, 8'h00, 5'b10010, exp_sr});
         end
         step();
      end
      drain();
   endtask

   task automatic test_ops_frozen();
`ifndef MATH_SEQ_SKID_EN
      send(8'h11, 8'h22, 8'h33);
      for (int i = 0; i < SETTLE; i++) begin
         s_valid = 1'b1;
         s_I1 = 8'($urandom);
         s_I2 = 8'($urandom);
         s_I3 = 8'($urandom);
         step();
         vectors++;
         if (last_acc || {op_I1, op_I2, op_I3} !== 24'h112233) begin
            errors++;
            $display("FAIL ops_frozen: acc %b op %h expected acc 0 op 112233", last_acc, {op_I1, op_I2, op_I3});
         end
      end
      s_valid = 1'b0;
      drain();
`endif
   endtask

   task automatic test_reset_mid();
      m_ready = 1'b1;
      send(8'h05, 8'h06, 8'h07);
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({m_valid, s_ready, busy} !== 3'b010 || {op_I1, op_I2, op_I3} !== 24'h0) begin
         errors++;
         $display("FAIL reset_mid: {m_valid,s_ready,busy}=%b op=%h expected 010 op=0",
                  {m_valid, s_ready, busy}, {op_I1, op_I2, op_I3});
      end
      step();
      step();
      exp_q.delete();
      acc_q.delete();
      rst_n = 1'b1;
      step();
      send(8'h0A, 8'h0B, 8'h0C);
      wait_mv();
      vectors++;
      if ({m_sum, m_sub} !== {8'h15, 8'hFF}) begin
         errors++;
         $display("FAIL after_reset: got %h expected 15ff", {m_sum, m_sub});
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] d [4][3];
      int k = 0, got = 0, last = 0, sp;
      bit mvp;
`ifdef MATH_SEQ_SKID_EN
      sp = SETTLE + 1;
`else
      sp = SETTLE + 2;
`endif
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 3; j++) d[i][j] = 8'($urandom);
      m_ready = 1'b1;
      s_valid = 1'b1;
      {s_I1, s_I2, s_I3} = {d[0][0], d[0][1], d[0][2]};
      mvp = m_valid;
      for (int n = 0; n < 200 && got < 4; n++) begin
         step();
         if (last_acc) begin
            k++;
            if (k < 4) {s_I1, s_I2, s_I3} = {d[k][0], d[k][1], d[k][2]};
            else s_valid = 1'b0;
         end
         if (m_valid && !mvp) begin
            if (got > 0) begin
               vectors++;
               if (cyc - last !== sp) begin
                  errors++;
                  $display("FAIL b2b_spacing: got %0d expected %0d", cyc - last, sp);
               end
            end
            last = cyc;
            got++;
         end
         mvp = m_valid;
      end
      s_valid = 1'b0;
      vectors++;
      if (got !== 4) begin
         errors++;
         $display("FAIL b2b_count: got %0d expected 4", got);
      end
      drain();
   endtask

   task automatic test_wrap();
      m_ready = 1'b1;
      send(8'h80, 8'h80, 8'h80);
      wait_mv();
      vectors++;
      if ({m_sum, m_sub, m_flags} !== {8'h00, 8'h00, 5'b01010}) begin
         errors++;
         $display("FAIL wrap_eq: got %h expected %h", {m_sum, m_sub, m_flags}, {8'h00, 8'h00, 5'b01010});
      end
      drain();
      send(8'h80, 8'h80, 8'h7F);
      wait_mv();
      vectors++;
      if ({m_sum, m_sub, m_flags} !== {8'h00, 8'h00, 5'b10010}) begin
         errors++;
         $display("FAIL wrap_neq: got %h expected %h", {m_sum, m_sub, m_flags}, {8'h00, 8'h00, 5'b10010});
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold_result();
      test_ops_frozen();
      test_reset_mid();
      test_back_to_back();
      test_wrap();
      vectors++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d results missing expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
